adc_scan_sched: RTL and testbench

//   Multi-channel scan scheduler for the ADC0809 conversion engine.

---
 rtl/adc_scan_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_scan_sched.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sched.sv
// adc_scan_sched: walks the enabled ADC0809 inputs once per scan round,
// serialises one conversion per channel onto the single converter and keeps
// the latest result of every channel in a small readable bank.
module adc_scan_sched #(
  parameter int SCAN_DIV  = 128000,
  parameter int SETUP_CYC = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       single_req,
  input  logic [7:0] ch_mask,
  output logic [2:0] conv_ch,
  output logic       conv_req,
  input  logic       conv_done,
  input  logic [7:0] conv_data,
  output logic       res_wr,
  output logic [2:0] res_ch,
  output logic [7:0] res_data,
  output logic [7:0] res_valid,
  input  logic [2:0] rd_ch,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       timeout_err,
  output logic       overrun_err,
  input  logic       err_clr
);

  localparam int TICK_W  = $clog2(SCAN_DIV + 1);
  localparam int SETUP_W = $clog2(SETUP_CYC + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(SCAN_DIV - 1);
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYC - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_WAIT,
    S_STORE,
    S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SETUP_W-1:0]  setup_cnt_q, setup_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [7:0]          mask_q, mask_d;
  logic [7:0]          data_q, data_d;
  logic [7:0]          bank_q [8];
  logic [7:0]          bank_d [8];
  logic [2:0]          conv_ch_q, conv_ch_d;
  logic                conv_req_q, conv_req_d;
  logic                res_wr_q, res_wr_d;
  logic [2:0]          res_ch_q, res_ch_d;
  logic [7:0]          res_data_q, res_data_d;
  logic [7:0]          res_valid_q, res_valid_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic                overrun_err_q, overrun_err_d;
  logic                tick;
  logic                timeout_set;
  logic                overrun_set;
  logic [7:0]          remaining;

  // Lowest enabled channel of a mask; scanning always proceeds upwards.
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Scan-round divider: runs only while scanning is enabled and emits a tick on wrap.
  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (!scan_en) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
      tick       = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  // Scan sequencer: next state, channel walk, result bank, read port and error flags.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    to_cnt_d    = to_cnt_q;
    mask_d      = mask_q;
    data_d      = data_q;
    bank_d      = bank_q;
    conv_ch_d   = conv_ch_q;
    conv_req_d  = 1'b0;
    res_wr_d    = 1'b0;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    rd_data_d   = bank_q[rd_ch];
    timeout_set = 1'b0;
    overrun_set = tick && (state_q != S_IDLE);
    remaining   = mask_q & ~(8'd1 << conv_ch_q);

    case (state_q)
      S_IDLE: begin
        if ((tick || single_req) && (ch_mask != 8'd0)) begin
          mask_d      = ch_mask;
          conv_ch_d   = lowest_bit(ch_mask);
          setup_cnt_d = '0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          conv_req_d = 1'b1;
          state_d    = S_REQ;
        end else begin
          setup_cnt_d = setup_cnt_q + SETUP_W'(1);
        end
      end
      S_REQ: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (conv_done) begin
          data_d  = conv_data;
          state_d = S_STORE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_set = 1'b1;
          state_d     = S_NEXT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_STORE: begin
        bank_d[conv_ch_q]      = data_q;
        res_valid_d[conv_ch_q] = 1'b1;
        res_wr_d               = 1'b1;
        res_ch_d               = conv_ch_q;
        res_data_d             = data_q;
        state_d                = S_NEXT;
      end
      S_NEXT: begin
        mask_d = remaining;
        if (remaining != 8'd0) begin
          conv_ch_d   = lowest_bit(remaining);
          setup_cnt_d = '0;
          state_d     = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d        = (state_d != S_IDLE);
    timeout_err_d = err_clr ? 1'b0 : (timeout_err_q | timeout_set);
    overrun_err_d = err_clr ? 1'b0 : (overrun_err_q | overrun_set);
  end

  // State and output registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      setup_cnt_q   <= '0;
      to_cnt_q      <= '0;
      mask_q        <= '0;
      data_q        <= '0;
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
      conv_ch_q     <= '0;
      conv_req_q    <= 1'b0;
      res_wr_q      <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      res_valid_q   <= '0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      setup_cnt_q   <= setup_cnt_d;
      to_cnt_q      <= to_cnt_d;
      mask_q        <= mask_d;
      data_q        <= data_d;
      bank_q        <= bank_d;
      conv_ch_q     <= conv_ch_d;
      conv_req_q    <= conv_req_d;
      res_wr_q      <= res_wr_d;
      res_ch_q      <= res_ch_d;
      res_data_q    <= res_data_d;
      res_valid_q   <= res_valid_d;
      rd_data_q     <= rd_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign conv_ch     = conv_ch_q;
  assign conv_req    = conv_req_q;
  assign res_wr      = res_wr_q;
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_adc_scan_sched.sv
// tb_adc_scan_sched: drives adc_scan_sched with directed scenarios and a
// randomized phase, predicting every output from a timeline of planned events.
module tb_adc_scan_sched;

  localparam int SCAN_DIV  = 100;
  localparam int SETUP_CYC = 4;
  localparam int TIMEOUT   = 16;

  logic       clk;
  logic       rst;
  logic       scan_en;
  logic       single_req;
  logic [7:0] ch_mask;
  logic [2:0] conv_ch;
  logic       conv_req;
  logic       conv_done;
  logic [7:0] conv_data;
  logic       res_wr;
  logic [2:0] res_ch;
  logic [7:0] res_data;
  logic [7:0] res_valid;
  logic [2:0] rd_ch;
  logic [7:0] rd_data;
  logic       busy;
  logic       timeout_err;
  logic       overrun_err;
  logic       err_clr;

  adc_scan_sched #(
    .SCAN_DIV (SCAN_DIV),
    .SETUP_CYC(SETUP_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .single_req (single_req),
    .ch_mask    (ch_mask),
    .conv_ch    (conv_ch),
    .conv_req   (conv_req),
    .conv_done  (conv_done),
    .conv_data  (conv_data),
    .res_wr     (res_wr),
    .res_ch     (res_ch),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .busy       (busy),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .err_clr    (err_clr)
  );

  // Counters for the summary line.
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Planned event timeline, keyed by absolute cycle number.
  int chg_at    [int];
  int req_at    [int];
  int wr_ch_at  [int];
  int wr_dat_at [int];
  int done_at   [int];
  bit wait_cyc  [int];
  bit tmo_at    [int];

  // Expected architectural state.
  logic [2:0] m_ch, m_res_ch;
  logic [7:0] m_res_data, m_valid, m_rd_next;
  logic [7:0] m_bank [8];
  bit         m_tmo, m_ovr, prev_clr, prev_ovr_set, m_tick, busy_exp;
  int         run_len, first_busy, last_busy, m_c;
  int         req_seen = 0;
  int         wr_seen  = 0;

  // Responder configuration.
  int         fixed_j     = -1;
  logic [7:0] tmo_mask    = 8'h00;
  bit         use_tbl     = 0;
  logic [7:0] data_tbl [8];
  bit         noise_en    = 0;
  bit         manual_done = 0;
  int         r_c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic void reset_model();
    chg_at.delete();
    req_at.delete();
    wr_ch_at.delete();
    wr_dat_at.delete();
    done_at.delete();
    wait_cyc.delete();
    tmo_at.delete();
    m_ch         = 3'd0;
    m_res_ch     = 3'd0;
    m_res_data   = 8'd0;
    m_valid      = 8'd0;
    m_rd_next    = 8'd0;
    for (int i = 0; i < 8; i++) m_bank[i] = 8'd0;
    m_tmo        = 0;
    m_ovr        = 0;
    prev_clr     = 0;
    prev_ovr_set = 0;
    run_len      = 0;
    first_busy   = 0;
    last_busy    = -1;
  endfunction

  // Lay out a whole round: each enabled channel in ascending order gets
  // SETUP_CYC setup cycles, one request cycle, a wait window, then either
  // store+next (converted) or next alone (timed out).
  task automatic plan_round(input int c, input logic [7:0] mask);
    int a, x, j, d;
    bit to;
    a = c + 1;
    x = c;
    for (int ch = 0; ch < 8; ch++) begin
      if (mask[ch]) begin
        chg_at[a] = ch;
        req_at[a + SETUP_CYC] = ch;
        to = tmo_mask[ch] || (fixed_j < 0 && $urandom_range(0, 5) == 0);
        if (to) begin
          for (int k = 0; k < TIMEOUT; k++) wait_cyc[a + SETUP_CYC + 1 + k] = 1;
          x = a + SETUP_CYC + TIMEOUT + 1;
          tmo_at[x] = 1;
        end else begin
          j = (fixed_j >= 0) ? fixed_j : $urandom_range(0, TIMEOUT - 1);
          d = use_tbl ? int'(data_tbl[ch]) : $urandom_range(0, 255);
          for (int k = 0; k <= j; k++) wait_cyc[a + SETUP_CYC + 1 + k] = 1;
          done_at[a + SETUP_CYC + 1 + j] = d;
          x = a + SETUP_CYC + 3 + j;
          wr_ch_at[x]  = ch;
          wr_dat_at[x] = d;
        end
        a = x + 1;
      end
    end
    first_busy = c + 1;
    last_busy  = x;
  endtask

  // Conversion responder: answers planned requests, plus optional stray pulses
  // outside any wait window.
  initial begin
    conv_done = 1'b0;
    conv_data = 8'd0;
    forever begin
      @(posedge clk);
      #2;
      r_c = cyc;
      if (done_at.exists(r_c)) begin
        conv_done = 1'b1;
        conv_data = 8'(done_at[r_c]);
      end else if (manual_done || (noise_en && !wait_cyc.exists(r_c) && $urandom_range(0, 15) == 0)) begin
        conv_done = 1'b1;
        conv_data = 8'($urandom);
      end else begin
        conv_done = 1'b0;
        conv_data = 8'($urandom);
      end
    end
  end

  // Compare process: every cycle, derive expected outputs from the timeline and check them.
  initial begin
    reset_model();
    forever begin
      @(negedge clk);
      m_c = cyc;
      if (rst === 1'b1) begin
        reset_model();
      end else begin
        if (chg_at.exists(m_c)) m_ch = 3'(chg_at[m_c]);
        if (wr_ch_at.exists(m_c)) begin
          m_res_ch           = 3'(wr_ch_at[m_c]);
          m_res_data         = 8'(wr_dat_at[m_c]);
          m_valid[m_res_ch]  = 1'b1;
          m_bank[m_res_ch]   = m_res_data;
        end
        m_tmo = prev_clr ? 1'b0 : (m_tmo | tmo_at.exists(m_c));
        m_ovr = prev_clr ? 1'b0 : (m_ovr | prev_ovr_set);
      end
      busy_exp = (rst !== 1'b1) && (m_c >= first_busy) && (m_c <= last_busy);

      check_output("busy",        32'(busy),        32'(busy_exp));
      check_output("conv_ch",     32'(conv_ch),     32'(m_ch));
      check_output("conv_req",    32'(conv_req),    32'(req_at.exists(m_c) ? 1 : 0));
      check_output("res_wr",      32'(res_wr),      32'(wr_ch_at.exists(m_c) ? 1 : 0));
      check_output("res_ch",      32'(res_ch),      32'(m_res_ch));
      check_output("res_data",    32'(res_data),    32'(m_res_data));
      check_output("res_valid",   32'(res_valid),   32'(m_valid));
      check_output("rd_data",     32'(rd_data),     32'(m_rd_next));
      check_output("timeout_err", 32'(timeout_err), 32'(m_tmo));
      check_output("overrun_err", 32'(overrun_err), 32'(m_ovr));

      if (conv_req === 1'b1) req_seen++;
      if (res_wr === 1'b1) wr_seen++;

      if (rst !== 1'b1) begin
        m_tick       = (scan_en === 1'b1) && ((run_len % SCAN_DIV) == SCAN_DIV - 1);
        run_len      = (scan_en === 1'b1) ? run_len + 1 : 0;
        prev_ovr_set = m_tick && busy_exp;
        if (!busy_exp && (m_tick || single_req === 1'b1) && ch_mask != 8'd0)
          plan_round(m_c, ch_mask);
        prev_clr  = (err_clr === 1'b1);
        m_rd_next = m_bank[rd_ch];
      end
    end
  end

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_single();
    single_req = 1'b1;
    tick_wait(1);
    single_req = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick_wait(1);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    tick_wait(2);
    while (busy !== 1'b0 && n < limit) begin
      tick_wait(1);
      n++;
    end
    check_output(name, 32'(busy), 32'd0);
  endtask

  // Directed scenarios followed by a randomized run.
  task automatic apply_stimulus();
    int r0, w0, n;

    // Reset state.
    check_output("reset_busy",      32'(busy),        32'd0);
    check_output("reset_res_valid", 32'(res_valid),   32'd0);
    check_output("reset_conv_ch",   32'(conv_ch),     32'd0);

    // Single round over channels 0 and 2 with fixed results.
    use_tbl     = 1;
    data_tbl[0] = 8'hA5;
    data_tbl[2] = 8'h3C;
    fixed_j     = 3;
    ch_mask     = 8'h05;
    r0 = req_seen;
    pulse_single();
    check_output("t1_first_ch", 32'(conv_ch), 32'd0);
    wait_idle(300, "t1_idle");
    rd_ch = 3'd2;
    tick_wait(2);
    check_output("t1_rd_ch2",     32'(rd_data),     32'h3C);
    check_output("t1_res_valid",  32'(res_valid),   32'h05);
    check_output("t1_req_count",  32'(req_seen - r0), 32'd2);
    check_output("t1_last_ch",    32'(conv_ch),     32'd2);
    use_tbl = 0;

    // Channel 0 never answers; channel 1 still converts.
    pulse_rst();
    tmo_mask = 8'h01;
    fixed_j  = 2;
    ch_mask  = 8'h03;
    pulse_single();
    wait_idle(300, "t3_idle");
    check_output("t3_timeout_err", 32'(timeout_err), 32'd1);
    check_output("t3_res_valid",   32'(res_valid),   32'h02);
    err_clr = 1'b1;
    tick_wait(1);
    err_clr = 1'b0;
    check_output("t3_err_clr", 32'(timeout_err), 32'd0);
    tmo_mask = 8'h00;

    // Periodic scanning of channel 7 with a conversion taking 10 cycles.
    fixed_j = 9;
    ch_mask = 8'h80;
    w0 = wr_seen;
    scan_en = 1'b1;
    tick_wait(320);
    scan_en = 1'b0;
    check_output("t2_round_count", 32'(wr_seen - w0), 32'd3);
    check_output("t2_res_ch",      32'(res_ch),       32'd7);
    check_output("t2_overrun",     32'(overrun_err),  32'd0);

    // Rounds longer than the tick period: overrun, no overlap.
    fixed_j = 15;
    ch_mask = 8'hFF;
    scan_en = 1'b1;
    tick_wait(250);
    check_output("t4_overrun", 32'(overrun_err), 32'd1);
    scan_en = 1'b0;
    wait_idle(600, "t4_idle");
    err_clr = 1'b1;
    tick_wait(1);
    err_clr = 1'b0;
    check_output("t4_err_clr", 32'(overrun_err), 32'd0);

    // Mask change mid-round affects only the next round.
    fixed_j = -1;
    ch_mask = 8'h0F;
    r0 = req_seen;
    pulse_single();
    tick_wait(3);
    ch_mask = 8'h01;
    wait_idle(600, "t5_idle1");
    check_output("t5_round1_reqs", 32'(req_seen - r0), 32'd4);
    r0 = req_seen;
    pulse_single();
    wait_idle(600, "t5_idle2");
    check_output("t5_round2_reqs", 32'(req_seen - r0), 32'd1);

    // Reset while waiting for a conversion; a late done must not store.
    fixed_j = 15;
    ch_mask = 8'hFF;
    pulse_single();
    n = 0;
    while (conv_req !== 1'b1 && n < 60) begin
      tick_wait(1);
      n++;
    end
    check_output("t6_req_seen", 32'(conv_req), 32'd1);
    tick_wait(3);
    rst = 1'b1;
    #1;
    check_output("t6_busy",      32'(busy),        32'd0);
    check_output("t6_conv_req",  32'(conv_req),    32'd0);
    check_output("t6_res_valid", 32'(res_valid),   32'd0);
    check_output("t6_errs",      32'({timeout_err, overrun_err}), 32'd0);
    tick_wait(1);
    rst = 1'b0;
    w0 = wr_seen;
    manual_done = 1;
    tick_wait(1);
    manual_done = 0;
    tick_wait(10);
    check_output("t6_no_store", 32'(wr_seen - w0), 32'd0);

    // Randomized traffic, with stray done pulses and one mid-run reset.
    fixed_j  = -1;
    noise_en = 1;
    for (int i = 0; i < 3000; i++) begin
      single_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) ch_mask = 8'($urandom);
      if ($urandom_range(0, 499) == 0) scan_en = ~scan_en;
      err_clr = ($urandom_range(0, 49) == 0);
      rd_ch   = 3'($urandom);
      rst     = (i == 1500);
      tick_wait(1);
    end
    single_req = 1'b0;
    err_clr    = 1'b0;
    rst        = 1'b0;
    scan_en    = 1'b0;
    noise_en   = 0;
    wait_idle(600, "rand_idle");
  endtask

  initial begin
    rst        = 1'b1;
    scan_en    = 1'b0;
    single_req = 1'b0;
    ch_mask    = 8'h00;
    rd_ch      = 3'd0;
    err_clr    = 1'b0;
    for (int i = 0; i < 8; i++) data_tbl[i] = 8'h00;
    tick_wait(3);
    rst = 1'b0;
    apply_stimulus();
    tick_wait(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
